// File: rtl/msgpass_wr_arbiter_pkg.sv
// Shared configuration for the message-passing buffer and its write-side arbiter.
// Holds buffer geometry, request FIFO depth, the request record and priority type.
package msgPass_config_pkg;

  localparam int MSGPASS_BUFF_ADDR_WIDTH  = 8;
  localparam int MSGPASS_BUFF_RDATA_WIDTH = 32;
  localparam int MSGPASS_WR_FIFO_DEPTH    = 4;

  typedef struct packed {
    logic [MSGPASS_BUFF_ADDR_WIDTH-1:0]  addr;
    logic [MSGPASS_BUFF_RDATA_WIDTH-1:0] data;
  } msgpass_wr_req_t;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } msgpass_wr_prio_e;

  function automatic msgpass_wr_prio_e msgpass_wr_prio_flip(input msgpass_wr_prio_e prio);
    return (prio == PRIO_A) ? PRIO_B : PRIO_A;
  endfunction

endpackage

// File: rtl/msgpass_wr_arbiter_req_fifo.sv
// Synchronous request FIFO for one write port of the arbiter.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module msgpass_wr_req_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[IDX_W-1:0]];

  // A flush cycle discards the incoming push and any pop along with the contents.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = din_i;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/msgpass_wr_arbiter.sv
// Write-side front end of the dual-port message buffer: queues two request streams and
// issues up to two writes per cycle, serialising same-address pairs round-robin.
module msgpass_wr_arbiter
  import msgPass_config_pkg::*;
#(
  parameter int ADDR_W     = MSGPASS_BUFF_ADDR_WIDTH,
  parameter int DATA_W     = MSGPASS_BUFF_RDATA_WIDTH,
  parameter int FIFO_DEPTH = MSGPASS_WR_FIFO_DEPTH,
  parameter int CNT_W      = 16
) (
  input  logic              sys_clk_i,
  input  logic              rst_i,
  input  logic              flush_i,

  input  logic              reqA_valid_i,
  output logic              reqA_ready_o,
  input  logic [ADDR_W-1:0] reqA_addr_i,
  input  logic [DATA_W-1:0] reqA_data_i,

  input  logic              reqB_valid_i,
  output logic              reqB_ready_o,
  input  logic [ADDR_W-1:0] reqB_addr_i,
  input  logic [DATA_W-1:0] reqB_data_i,

  output logic [ADDR_W-1:0] waddr_portA_o,
  output logic [DATA_W-1:0] wdata_portA_o,
  output logic              wen_portA_o,

  output logic [ADDR_W-1:0] waddr_portB_o,
  output logic [DATA_W-1:0] wdata_portB_o,
  output logic              wen_portB_o,

  output logic              idle_o,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  localparam int REQ_W = ADDR_W + DATA_W;

  logic              full_a, empty_a, pop_a;
  logic              full_b, empty_b, pop_b;
  logic [REQ_W-1:0]  head_a, head_b;
  logic [ADDR_W-1:0] head_a_addr, head_b_addr;
  logic [DATA_W-1:0] head_a_data, head_b_data;

  logic              issue_a, issue_b, collide;

  msgpass_wr_prio_e  prio_q, prio_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wen_a_q, wen_a_d;
  logic              wen_b_q, wen_b_d;
  logic [ADDR_W-1:0] waddr_a_q, waddr_a_d;
  logic [ADDR_W-1:0] waddr_b_q, waddr_b_d;
  logic [DATA_W-1:0] wdata_a_q, wdata_a_d;
  logic [DATA_W-1:0] wdata_b_q, wdata_b_d;

  assign reqA_ready_o = !full_a;
  assign reqB_ready_o = !full_b;

  msgpass_wr_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_a (
    .clk_i   (sys_clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (reqA_valid_i),
    .pop_i   (pop_a),
    .din_i   ({reqA_addr_i, reqA_data_i}),
    .full_o  (full_a),
    .empty_o (empty_a),
    .head_o  (head_a)
  );

  msgpass_wr_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_b (
    .clk_i   (sys_clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (reqB_valid_i),
    .pop_i   (pop_b),
    .din_i   ({reqB_addr_i, reqB_data_i}),
    .full_o  (full_b),
    .empty_o (empty_b),
    .head_o  (head_b)
  );

  assign head_a_addr = head_a[REQ_W-1 -: ADDR_W];
  assign head_a_data = head_a[DATA_W-1:0];
  assign head_b_addr = head_b[REQ_W-1 -: ADDR_W];
  assign head_b_data = head_b[DATA_W-1:0];

  // Arbitration is suppressed during flush so a dropped head never counts as a collision.
  always_comb begin
    issue_a = 1'b0;
    issue_b = 1'b0;
    collide = 1'b0;
    if (!flush_i) begin
      if (!empty_a && !empty_b && (head_a_addr == head_b_addr)) begin
        collide = 1'b1;
        issue_a = (prio_q == PRIO_A);
        issue_b = (prio_q == PRIO_B);
      end else begin
        issue_a = !empty_a;
        issue_b = !empty_b;
      end
    end
  end

  assign pop_a = issue_a;
  assign pop_b = issue_b;

  always_comb begin
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    wen_a_d   = !issue_a;
    wen_b_d   = !issue_b;
    waddr_a_d = waddr_a_q;
    wdata_a_d = wdata_a_q;
    waddr_b_d = waddr_b_q;
    wdata_b_d = wdata_b_q;
    if (issue_a) begin
      waddr_a_d = head_a_addr;
      wdata_a_d = head_a_data;
    end
    if (issue_b) begin
      waddr_b_d = head_b_addr;
      wdata_b_d = head_b_data;
    end
    if (collide) begin
      prio_d = msgpass_wr_prio_flip(prio_q);
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      prio_q    <= PRIO_A;
      cnt_q     <= '0;
      wen_a_q   <= 1'b1;
      wen_b_q   <= 1'b1;
      waddr_a_q <= '0;
      wdata_a_q <= '0;
      waddr_b_q <= '0;
      wdata_b_q <= '0;
    end else begin
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      wen_a_q   <= wen_a_d;
      wen_b_q   <= wen_b_d;
      waddr_a_q <= waddr_a_d;
      wdata_a_q <= wdata_a_d;
      waddr_b_q <= waddr_b_d;
      wdata_b_q <= wdata_b_d;
    end
  end

  assign waddr_portA_o  = waddr_a_q;
  assign wdata_portA_o  = wdata_a_q;
  assign wen_portA_o    = wen_a_q;
  assign waddr_portB_o  = waddr_b_q;
  assign wdata_portB_o  = wdata_b_q;
  assign wen_portB_o    = wen_b_q;
  assign conflict_cnt_o = cnt_q;
  assign idle_o         = empty_a && empty_b && wen_a_q && wen_b_q;

  // The buffer must never see both ports writing the same word in one cycle.
  assert property (@(posedge sys_clk_i) disable iff (rst_i)
    !(!wen_a_q && !wen_b_q && (waddr_a_q == waddr_b_q)));

endmodule

// File: tb/tb_msgpass_wr_arbiter.sv
// Directed bench for msgpass_wr_arbiter: per-port expected-write queues are filled as
// requests are accepted and drained by a monitor that also keeps a model of the buffer.
module tb_msgpass_wr_arbiter;
  import msgPass_config_pkg::*;

  localparam int AW = MSGPASS_BUFF_ADDR_WIDTH;
  localparam int DW = MSGPASS_BUFF_RDATA_WIDTH;
  localparam int CW = 16;
  localparam int RW = AW + DW;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          reqA_valid, reqB_valid;
  logic          reqA_ready, reqB_ready;
  logic [AW-1:0] reqA_addr, reqB_addr;
  logic [DW-1:0] reqA_data, reqB_data;
  logic [AW-1:0] waddr_a, waddr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          wen_a, wen_b, idle;
  logic [CW-1:0] conflict_cnt;

  logic [RW-1:0] qA[$];
  logic [RW-1:0] qB[$];
  logic [DW-1:0] mem [256];

  int tests_run    = 0;
  int tests_failed = 0;

  msgpass_wr_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .FIFO_DEPTH (4),
    .CNT_W      (CW)
  ) dut (
    .sys_clk_i      (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .reqA_valid_i   (reqA_valid),
    .reqA_ready_o   (reqA_ready),
    .reqA_addr_i    (reqA_addr),
    .reqA_data_i    (reqA_data),
    .reqB_valid_i   (reqB_valid),
    .reqB_ready_o   (reqB_ready),
    .reqB_addr_i    (reqB_addr),
    .reqB_data_i    (reqB_data),
    .waddr_portA_o  (waddr_a),
    .wdata_portA_o  (wdata_a),
    .wen_portA_o    (wen_a),
    .waddr_portB_o  (waddr_b),
    .wdata_portB_o  (wdata_b),
    .wen_portB_o    (wen_b),
    .idle_o         (idle),
    .conflict_cnt_o (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic va, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                               input logic vb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    reqA_valid = va;
    reqA_addr  = aa;
    reqA_data  = da;
    reqB_valid = vb;
    reqB_addr  = ab;
    reqB_data  = db;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyCollision(input logic [DW-1:0] da, input logic [DW-1:0] db, input bit a_first);
    applyStimulus(1'b1, AW'(7), da, 1'b1, AW'(7), db);
    qA.push_back({AW'(7), da});
    qB.push_back({AW'(7), db});
    cyc(1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    cyc(1);
    checkOutput("coll_first_wenA", 64'(wen_a), a_first ? 64'd0 : 64'd1);
    checkOutput("coll_first_wenB", 64'(wen_b), a_first ? 64'd1 : 64'd0);
    cyc(1);
    checkOutput("coll_second_wenA", 64'(wen_a), a_first ? 64'd1 : 64'd0);
    checkOutput("coll_second_wenB", 64'(wen_b), a_first ? 64'd0 : 64'd1);
    cyc(1);
    checkOutput("coll_mem7", 64'(mem[7]), a_first ? 64'(db) : 64'(da));
  endtask

  task automatic waitIdle(input int budget);
    int k = 0;
    while (idle !== 1'b1 && k < budget) begin
      cyc(1);
      k++;
    end
    checkOutput("drain_idle", 64'(idle), 64'd1);
  endtask

  // Monitor: every active write must match the oldest outstanding request of its port.
  always @(negedge clk) begin
    logic [RW-1:0] e;
    if (wen_a === 1'b0) begin
      if (qA.size() == 0) checkOutput("unexpected_write_A", 64'(wen_a), 64'd1);
      else begin
        e = qA.pop_front();
        checkOutput("write_A", 64'({waddr_a, wdata_a}), 64'(e));
        mem[waddr_a] = wdata_a;
      end
    end
    if (wen_b === 1'b0) begin
      if (qB.size() == 0) checkOutput("unexpected_write_B", 64'(wen_b), 64'd1);
      else begin
        e = qB.pop_front();
        checkOutput("write_B", 64'({waddr_b, wdata_b}), 64'(e));
        mem[waddr_b] = wdata_b;
      end
    end
    if (wen_a === 1'b0 && wen_b === 1'b0)
      checkOutput("no_same_addr", 64'(waddr_a == waddr_b), 64'd0);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc_a, acc_b;
    bit low_a, low_b;
    rst   = 1'b1;
    flush = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    cyc(2);
    rst = 1'b0;
    checkOutput("rst_readyA", 64'(reqA_ready), 64'd1);
    checkOutput("rst_readyB", 64'(reqB_ready), 64'd1);
    checkOutput("rst_wenA", 64'(wen_a), 64'd1);
    checkOutput("rst_wenB", 64'(wen_b), 64'd1);
    checkOutput("rst_addrA", 64'(waddr_a), 64'd0);
    checkOutput("rst_dataB", 64'(wdata_b), 64'd0);
    checkOutput("rst_idle", 64'(idle), 64'd1);
    checkOutput("rst_cnt", 64'(conflict_cnt), 64'd0);

    // Independent addresses go out together two edges after acceptance.
    applyStimulus(1'b1, AW'(3), DW'(32'h11), 1'b1, AW'(5), DW'(32'h22));
    qA.push_back({AW'(3), DW'(32'h11)});
    qB.push_back({AW'(5), DW'(32'h22)});
    cyc(1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("lat_wenA_early", 64'(wen_a), 64'd1);
    checkOutput("lat_busy", 64'(idle), 64'd0);
    cyc(1);
    checkOutput("dual_wenA", 64'(wen_a), 64'd0);
    checkOutput("dual_wenB", 64'(wen_b), 64'd0);
    checkOutput("dual_addrA", 64'(waddr_a), 64'd3);
    checkOutput("dual_dataB", 64'(wdata_b), 64'h22);
    cyc(1);
    checkOutput("dual_wen_release", 64'({wen_a, wen_b}), 64'd3);
    checkOutput("dual_cnt", 64'(conflict_cnt), 64'd0);
    checkOutput("mem3", 64'(mem[3]), 64'h11);
    checkOutput("mem5", 64'(mem[5]), 64'h22);

    // Same-address collisions alternate winners.
    applyCollision(DW'(32'hAA), DW'(32'hBB), 1'b1);
    checkOutput("coll_cnt1", 64'(conflict_cnt), 64'd1);
    applyCollision(DW'(32'h1A), DW'(32'h1B), 1'b0);
    applyCollision(DW'(32'h2A), DW'(32'h2B), 1'b1);
    applyCollision(DW'(32'h3A), DW'(32'h3B), 1'b0);
    checkOutput("coll_cnt4", 64'(conflict_cnt), 64'd4);

    // Port A streaming alone drains one per cycle so it never backs up.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, AW'(8'h20 + i), DW'(32'hC0 + i), 1'b0, '0, '0);
      checkOutput("a_stream_ready", 64'(reqA_ready), 64'd1);
      qA.push_back({AW'(8'h20 + i), DW'(32'hC0 + i)});
      cyc(1);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    cyc(3);
    checkOutput("a_stream_drained", 64'(qA.size()), 64'd0);
    checkOutput("a_stream_idle", 64'(idle), 64'd1);

    // Colliding pushes build up three entries per port, then flush drops them.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, AW'(9), DW'(32'hF0 + i), 1'b1, AW'(9), DW'(32'hE0 + i));
      checkOutput("fill_readyA", 64'(reqA_ready), 64'd1);
      checkOutput("fill_readyB", 64'(reqB_ready), 64'd1);
      qA.push_back({AW'(9), DW'(32'hF0 + i)});
      qB.push_back({AW'(9), DW'(32'hE0 + i)});
      cyc(1);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    checkOutput("flush_leftA", 64'(qA.size()), 64'd3);
    checkOutput("flush_leftB", 64'(qB.size()), 64'd3);
    qA.delete();
    qB.delete();
    checkOutput("flush_wen", 64'({wen_a, wen_b}), 64'd3);
    checkOutput("flush_ready", 64'({reqA_ready, reqB_ready}), 64'd3);
    checkOutput("flush_cnt", 64'(conflict_cnt), 64'd8);
    cyc(2);
    checkOutput("flush_idle", 64'(idle), 64'd1);
    checkOutput("flush_cnt_kept", 64'(conflict_cnt), 64'd8);

    // Sustained colliding traffic halves drain rate until both FIFOs fill.
    acc_a = 0;
    acc_b = 0;
    low_a = 1'b0;
    low_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, AW'(9), DW'(32'hA000 + acc_a), 1'b1, AW'(9), DW'(32'hB000 + acc_b));
      if (reqA_ready) begin
        qA.push_back({AW'(9), DW'(32'hA000 + acc_a)});
        acc_a++;
      end else low_a = 1'b1;
      if (reqB_ready) begin
        qB.push_back({AW'(9), DW'(32'hB000 + acc_b)});
        acc_b++;
      end else low_b = 1'b1;
      cyc(1);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("backpressure_A", 64'(low_a), 64'd1);
    checkOutput("backpressure_B", 64'(low_b), 64'd1);
    waitIdle(60);
    checkOutput("bp_drainedA", 64'(qA.size()), 64'd0);
    checkOutput("bp_drainedB", 64'(qB.size()), 64'd0);

    // Reset mid-stream discards queued work and restores pointer and counter.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, AW'(4), DW'(32'h500 + i), 1'b1, AW'(4), DW'(32'h600 + i));
      qA.push_back({AW'(4), DW'(32'h500 + i)});
      qB.push_back({AW'(4), DW'(32'h600 + i)});
      cyc(1);
    end
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    rst = 1'b1;
    cyc(1);
    checkOutput("mid_rst_wen", 64'({wen_a, wen_b}), 64'd3);
    checkOutput("mid_rst_ready", 64'({reqA_ready, reqB_ready}), 64'd3);
    checkOutput("mid_rst_cnt", 64'(conflict_cnt), 64'd0);
    checkOutput("mid_rst_idle", 64'(idle), 64'd1);
    qA.delete();
    qB.delete();
    rst = 1'b0;
    cyc(3);
    checkOutput("post_rst_idle", 64'(idle), 64'd1);
    applyCollision(DW'(32'h7A), DW'(32'h7B), 1'b1);
    checkOutput("post_rst_cnt", 64'(conflict_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
